// File: rtl/mcs4_pkg.sv
// Shared MCS-4 types: instruction phase encoding, RAM I/O opcodes and RAM geometry.
package mcs4;

   typedef logic [3:0] char_t;

   typedef logic [3:0] instr_cyc_t;
   localparam instr_cyc_t CYC_UNSYNC = 4'd0;
   localparam instr_cyc_t CYC_A1     = 4'd1;
   localparam instr_cyc_t CYC_A2     = 4'd2;
   localparam instr_cyc_t CYC_A3     = 4'd3;
   localparam instr_cyc_t CYC_M1     = 4'd4;
   localparam instr_cyc_t CYC_M2     = 4'd5;
   localparam instr_cyc_t CYC_X1     = 4'd6;
   localparam instr_cyc_t CYC_X2     = 4'd7;
   localparam instr_cyc_t CYC_X3     = 4'd8;

   typedef enum logic [3:0] {
      OPA_WRM = 4'h0, OPA_WMP = 4'h1, OPA_WRR = 4'h2, OPA_WPM = 4'h3,
      OPA_WR0 = 4'h4, OPA_WR1 = 4'h5, OPA_WR2 = 4'h6, OPA_WR3 = 4'h7,
      OPA_SBM = 4'h8, OPA_RDM = 4'h9, OPA_RDR = 4'hA, OPA_ADM = 4'hB,
      OPA_RD0 = 4'hC, OPA_RD1 = 4'hD, OPA_RD2 = 4'hE, OPA_RD3 = 4'hF
   } ioram_opa_t;

   localparam int unsigned Ram_regs   = 4;
   localparam int unsigned Ram_chars  = 16;
   localparam int unsigned Ram_status = 4;
   localparam int unsigned Ram_words  = Ram_regs * (Ram_chars + Ram_status);

   typedef struct packed {
      logic [1:0] chip;
      logic [1:0] rsel;
   } ram_src_t;

   // Main characters occupy words 0..63, status characters 64..79.
   function automatic logic [6:0] main_addr(logic [1:0] r, char_t c);
      return {1'b0, r, c};
   endfunction

   function automatic logic [6:0] status_addr(logic [1:0] r, logic [1:0] idx);
      return {3'b100, r, idx};
   endfunction

endpackage

// File: rtl/i4002_ram_if.sv
// CPU <-> 4002 bus: sync, bank select and the 4-bit data bus.
interface i4002_ram_if;
   logic        sync;
   logic        cm_ram;
   mcs4::char_t dbus_in;
   mcs4::char_t dbus_out;
   logic        dbus_oe;

   modport master (output sync, cm_ram, dbus_in, input  dbus_out, dbus_oe);
   modport slave  (input  sync, cm_ram, dbus_in, output dbus_out, dbus_oe);
endinterface

// File: rtl/i4002_mem.sv
// 4002 storage: single write port (synchronous), single read port (combinational), not reset.
module i4002_mem
   import mcs4::*;
(
   input  logic       clk,
   input  logic       we_i,
   input  logic [6:0] waddr_i,
   input  char_t      wdata_i,
   input  logic [6:0] raddr_i,
   output char_t      rdata_o
);

   char_t mem_q [Ram_words];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i4002_ram.sv
// Intel 4002-style RAM chip: SRC address latch, I/O opcode decode and execution at X2.
module i4002_ram
   import mcs4::*;
#(
   parameter logic [1:0] CHIP_ID = 2'd0
) (
   input  logic              clk,
   input  logic              rst,
   i4002_ram_if.slave        bus,
   output char_t             io_out
);

   instr_cyc_t phase_q, phase_d;
   logic       selected_q, io_pend_q, src_x2_q;
   logic [1:0] rsel_q;
   char_t      char_q, io_out_q, rdata;
   ioram_opa_t opa_q;
   ram_src_t   src;

   logic       at_m2, at_x2, at_x3, exec, we, rd;
   logic [6:0] addr;

   assign src   = ram_src_t'(bus.dbus_in);
   assign at_m2 = (phase_q == CYC_M2);
   assign at_x2 = (phase_q == CYC_X2);
   assign at_x3 = (phase_q == CYC_X3);
   assign exec  = at_x2 && io_pend_q && !rst;

   always_comb begin
      phase_d = phase_q;
      if (bus.sync)                  phase_d = CYC_A1;
      else if (phase_q == CYC_X3)    phase_d = CYC_A1;
      else if (phase_q != CYC_UNSYNC) phase_d = phase_q + 4'd1;
   end

   always_comb begin
      we   = 1'b0;
      rd   = 1'b0;
      addr = main_addr(rsel_q, char_q);
      case (opa_q)
         OPA_WRM:                             we = exec;
         OPA_WR0, OPA_WR1, OPA_WR2, OPA_WR3: begin
            we   = exec;
            addr = status_addr(rsel_q, opa_q[1:0]);
         end
         OPA_SBM, OPA_RDM, OPA_ADM:           rd = exec;
         OPA_RD0, OPA_RD1, OPA_RD2, OPA_RD3: begin
            rd   = exec;
            addr = status_addr(rsel_q, opa_q[1:0]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= CYC_UNSYNC;
         selected_q <= 1'b0;
         rsel_q     <= '0;
         char_q     <= '0;
         opa_q      <= OPA_WRM;
         io_pend_q  <= 1'b0;
         src_x2_q   <= 1'b0;
         io_out_q   <= '0;
      end else begin
         phase_q <= phase_d;
         // X2 with cm_ram and no pending I/O is the address half of SRC.
         if (at_x2 && bus.cm_ram && !io_pend_q) begin
            selected_q <= (src.chip == CHIP_ID);
            rsel_q     <= src.rsel;
            src_x2_q   <= 1'b1;
         end
         if (at_x3) begin
            src_x2_q  <= 1'b0;
            io_pend_q <= 1'b0;
            if (bus.cm_ram && src_x2_q) char_q <= bus.dbus_in;
         end
         if (at_m2 && bus.cm_ram && selected_q) begin
            opa_q     <= ioram_opa_t'(bus.dbus_in);
            io_pend_q <= 1'b1;
         end
         if (exec && opa_q == OPA_WMP) io_out_q <= bus.dbus_in;
      end
   end

   i4002_mem u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (addr),
      .wdata_i (bus.dbus_in),
      .raddr_i (addr),
      .rdata_o (rdata)
   );

   assign bus.dbus_oe  = rd;
   assign bus.dbus_out = rd ? rdata : '0;
   assign io_out       = io_out_q;

endmodule

// File: tb/tb_i4002_ram.sv
// Directed bench for i4002_ram (CHIP_ID=1): SRC, main/status memory, output port, reset abort.
module tb_i4002_ram;
   import mcs4::*;

   logic  clk = 1'b0;
   logic  rst;
   char_t io_out;
   i4002_ram_if bus();

   int n_tests = 0;
   int n_fail  = 0;

   logic  x2_oe, other_bad;
   char_t x2_out, io_x2, io_x3;

   i4002_ram #(.CHIP_ID(2'd1)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus cycle: inputs applied just after posedge, outputs sampled at negedge.
   task automatic cyc(input logic s, input logic cm, input char_t d, input logic is_x2);
      bus.sync = s; bus.cm_ram = cm; bus.dbus_in = d;
      @(negedge clk);
      if (is_x2) begin
         x2_oe  = bus.dbus_oe;
         x2_out = bus.dbus_out;
      end else if (bus.dbus_oe !== 1'b0 || bus.dbus_out !== 4'h0) begin
         other_bad = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic instr(input logic m_cm, input char_t m_d, input logic x2_cm, input char_t x2_d,
                        input logic x3_cm, input char_t x3_d, input logic rst_m2);
      other_bad = 1'b0;
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b0, 1'b0, 4'hE, 1'b0);
      rst = rst_m2;
      cyc(1'b0, m_cm, m_d, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      io_x2 = io_out;
      cyc(1'b0, x2_cm, x2_d, 1'b1);
      io_x3 = io_out;
      cyc(1'b1, x3_cm, x3_d, 1'b0);
   endtask

   task automatic src(input char_t a, input char_t c);
      instr(1'b0, 4'h0, 1'b1, a, 1'b1, c, 1'b0);
   endtask

   task automatic io(input char_t opa, input char_t d);
      instr(1'b1, opa, 1'b0, d, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; bus.sync = 1'b0; bus.cm_ram = 1'b0; bus.dbus_in = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_oe", {7'd0, bus.dbus_oe}, 8'h0);
      check("rst_out", {4'd0, bus.dbus_out}, 8'h0);
      check("rst_io", {4'd0, io_out}, 8'h0);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 4'h0, 1'b0);

      src(4'h5, 4'h3);
      io(4'h0, 4'hA);
      check("wrm_oe", {7'd0, x2_oe}, 8'h0);
      check("wrm_quiet", {7'd0, other_bad}, 8'h0);
      io(4'h9, 4'h0);
      check("rdm_oe", {7'd0, x2_oe}, 8'h1);
      check("rdm_data", {4'd0, x2_out}, 8'hA);
      check("rdm_quiet", {7'd0, other_bad}, 8'h0);

      src(4'h9, 4'h0);
      io(4'h0, 4'h5);
      io(4'h9, 4'h0);
      check("other_chip_oe", {7'd0, x2_oe}, 8'h0);
      check("other_chip_out", {4'd0, x2_out}, 8'h0);
      src(4'h5, 4'h3);
      io(4'h9, 4'h0);
      check("chip1_kept", {4'd0, x2_out}, 8'hA);
      io(4'h8, 4'h0);
      check("sbm_data", {3'd0, x2_oe, x2_out}, 8'h1A);
      io(4'hB, 4'h0);
      check("adm_data", {3'd0, x2_oe, x2_out}, 8'h1A);

      src(4'h7, 4'h0);
      io(4'h5, 4'h4);
      io(4'h6, 4'h7);
      io(4'hE, 4'h0);
      check("rd2_data", {3'd0, x2_oe, x2_out}, 8'h17);
      io(4'hD, 4'h0);
      check("rd1_data", {3'd0, x2_oe, x2_out}, 8'h14);

      io(4'h1, 4'hC);
      check("wmp_before", {4'd0, io_x2}, 8'h0);
      check("wmp_after", {4'd0, io_x3}, 8'hC);
      check("wmp_oe", {7'd0, x2_oe}, 8'h0);
      io(4'h2, 4'h3);
      check("wrr_io", {3'd0, x2_oe, io_x3}, 8'h0C);
      io(4'hA, 4'h0);
      check("rdr_io", {3'd0, x2_oe, io_x3}, 8'h0C);
      check("rdr_out", {4'd0, x2_out}, 8'h0);

      src(4'h5, 4'h2);
      io(4'h0, 4'h6);
      instr(1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b1);
      check("rst_io_clear", {4'd0, io_out}, 8'h0);
      src(4'h5, 4'h2);
      io(4'h9, 4'h0);
      check("rst_no_write", {3'd0, x2_oe, x2_out}, 8'h16);
      src(4'h5, 4'h3);
      io(4'h9, 4'h0);
      check("rst_char3", {3'd0, x2_oe, x2_out}, 8'h1A);

      instr(1'b0, 4'h9, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      check("cm0_oe", {7'd0, x2_oe}, 8'h0);
      check("cm0_quiet", {7'd0, other_bad}, 8'h0);
      io(4'h9, 4'h0);
      check("cm0_then_rdm", {3'd0, x2_oe, x2_out}, 8'h1A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
